// File: rtl/axi4_sram_slave.sv
// AXI4 slave over a MEM_WORDS x 128-bit SRAM array. It supports INCR bursts only,
// with one outstanding write and one outstanding read. The write and read paths
// are independent, and every output is registered.
module axi4_sram_slave #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic         ACLK,
    input  logic         ARESETn,
    input  logic [31:0]  AWADDR,
    input  logic [7:0]   AWID,
    input  logic [3:0]   AWSIZE,
    input  logic [3:0]   AWLEN,
    input  logic         AWVALID,
    output logic         AWREADY,
    input  logic [127:0] WDATA,
    input  logic [15:0]  WSTRB,
    input  logic         WLAST,
    input  logic         WVALID,
    output logic         WREADY,
    output logic [7:0]   BID,
    output logic [1:0]   BRESP,
    output logic         BVALID,
    input  logic         BREADY,
    input  logic [31:0]  ARADDR,
    input  logic [7:0]   ARID,
    input  logic [3:0]   ARSIZE,
    input  logic [3:0]   ARLEN,
    input  logic         ARVALID,
    output logic         ARREADY,
    output logic [7:0]   RID,
    output logic [127:0] RDATA,
    output logic [1:0]   RRESP,
    output logic         RLAST,
    output logic         RVALID,
    input  logic         RREADY
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] WORDS = 32'(MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [127:0] mem [MEM_WORDS];

    // A beat is in error if it falls outside the array or uses an unsupported size
    function automatic logic beat_err(input logic [31:0] a, input logic [3:0] sz);
        return ({4'b0, a[31:4]} >= WORDS) || (sz > 4'd4);
    endfunction

    function automatic logic [31:0] addr_step(input logic [3:0] sz);
        return 32'd1 << sz;
    endfunction

    // ---------------- write path ----------------
    wstate_t     w_state;
    logic [31:0] w_addr;
    logic [7:0]  w_id;
    logic [3:0]  w_size;
    logic [3:0]  w_len;
    logic [3:0]  w_beat;
    logic        w_err;
    logic        w_hs_c;
    logic        w_beat_err_c;
    logic        w_last_c;
    logic        w_lasterr_c;

    assign w_hs_c       = (w_state == W_DATA) && WVALID && WREADY;
    assign w_beat_err_c = beat_err(w_addr, w_size);
    assign w_last_c     = (w_beat == w_len);
    assign w_lasterr_c  = (WLAST != w_last_c);

    // Write FSM: address accept, data beats, then hold the response until BREADY
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_id    <= '0;
            w_size  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    AWREADY <= 1'b1;
                    if (AWVALID && AWREADY) begin
                        w_addr  <= AWADDR;
                        w_id    <= AWID;
                        w_size  <= AWSIZE;
                        w_len   <= AWLEN;
                        w_beat  <= '0;
                        w_err   <= 1'b0;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_c) begin
                        if (w_beat_err_c || w_lasterr_c) w_err <= 1'b1;
                        if (w_last_c) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BID     <= w_id;
                            BRESP   <= (w_err || w_beat_err_c || w_lasterr_c) ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end else begin
                            w_addr <= w_addr + addr_step(w_size);
                            w_beat <= w_beat + 4'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (BVALID && BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Byte-lane array write; contents are deliberately not reset
    always_ff @(posedge ACLK) begin
        if (w_hs_c && !w_beat_err_c) begin
            for (int i = 0; i < 16; i++) begin
                if (WSTRB[i]) mem[w_addr[4 +: IDX_W]][8*i +: 8] <= WDATA[8*i +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rstate_t      r_state;
    logic [31:0]  r_addr;
    logic [7:0]   r_id;
    logic [3:0]   r_size;
    logic [3:0]   r_len;
    logic [3:0]   r_beat;
    logic         r_hs_c;
    logic [31:0]  ld_addr_c;
    logic [3:0]   ld_size_c;
    logic         ld_err_c;
    logic [127:0] ld_data_c;

    // Address of the beat loaded at this edge: the request itself or the next step
    assign r_hs_c    = (r_state == R_DATA) && RVALID && RREADY;
    assign ld_addr_c = (r_state == R_IDLE) ? ARADDR : (r_addr + addr_step(r_size));
    assign ld_size_c = (r_state == R_IDLE) ? ARSIZE : r_size;
    assign ld_err_c  = beat_err(ld_addr_c, ld_size_c);
    assign ld_data_c = ld_err_c ? '0 : mem[ld_addr_c[4 +: IDX_W]];

    // Read FSM: accept the request, then stream beats at full throughput
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_id    <= '0;
            r_size  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= '0;
            RLAST   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        r_addr  <= ARADDR;
                        r_id    <= ARID;
                        r_size  <= ARSIZE;
                        r_len   <= ARLEN;
                        r_beat  <= '0;
                        ARREADY <= 1'b0;
                        RVALID  <= 1'b1;
                        RID     <= ARID;
                        RDATA   <= ld_data_c;
                        RRESP   <= ld_err_c ? 2'b10 : 2'b00;
                        RLAST   <= (ARLEN == 4'd0);
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs_c) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= ld_addr_c;
                            r_beat <= r_beat + 4'd1;
                            RDATA  <= ld_data_c;
                            RRESP  <= ld_err_c ? 2'b10 : 2'b00;
                            RLAST  <= ((r_beat + 4'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: a byte-level memory model predicts the
// B responses and R beats. The predictions are queued at issue and popped on handshake.
module tb_axi4_sram_slave;

    localparam int unsigned MW = 256;

    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic [31:0]  AWADDR;
    logic [7:0]   AWID;
    logic [3:0]   AWSIZE;
    logic [3:0]   AWLEN;
    logic         AWVALID;
    logic         AWREADY;
    logic [127:0] WDATA;
    logic [15:0]  WSTRB;
    logic         WLAST;
    logic         WVALID;
    logic         WREADY;
    logic [7:0]   BID;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [31:0]  ARADDR;
    logic [7:0]   ARID;
    logic [3:0]   ARSIZE;
    logic [3:0]   ARLEN;
    logic         ARVALID;
    logic         ARREADY;
    logic [7:0]   RID;
    logic [127:0] RDATA;
    logic [1:0]   RRESP;
    logic         RLAST;
    logic         RVALID;
    logic         RREADY;

    axi4_sram_slave #(.MEM_WORDS(MW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWID(AWID), .AWSIZE(AWSIZE), .AWLEN(AWLEN),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARID(ARID), .ARSIZE(ARSIZE), .ARLEN(ARLEN),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed { logic [7:0] id; logic [1:0] resp; } bexp_t;
    typedef struct packed { logic [127:0] data; logic [1:0] resp; logic last; logic [7:0] id; } rexp_t;

    bexp_t        bq [$];
    rexp_t        rq [$];
    logic [127:0] mdl [MW];
    logic [127:0] wd [16];
    logic [15:0]  ws [16];
    logic         wl [16];

    int n_vec = 0;
    int n_err = 0;
    int rmode = 0;
    int bhold = 0;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic mdl_err(input logic [31:0] a, input logic [3:0] sz);
        return (a >= 32'(MW * 16)) || (sz > 4'd4);
    endfunction

    // Predict the response, update the model, then drive AW and all W beats
    task automatic do_write(input logic [31:0] addr, input logic [7:0] id,
                            input logic [3:0] size, input logic [3:0] len);
        logic        err;
        logic [31:0] a;
        int          t;
        err = 1'b0;
        a   = addr;
        for (int b = 0; b <= int'(len); b++) begin
            if (mdl_err(a, size)) err = 1'b1;
            else for (int i = 0; i < 16; i++)
                if (ws[b][i]) mdl[a[11:4]][8*i +: 8] = wd[b][8*i +: 8];
            if (wl[b] != (b == int'(len))) err = 1'b1;
            a = a + (32'd1 << size);
        end
        bq.push_back({id, err ? 2'b10 : 2'b00});
        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWADDR = addr; AWID = id; AWSIZE = size; AWLEN = len;
        t = 0;
        do begin @(negedge ACLK); t++; end while (!AWREADY && t < 200);
        if (!AWREADY) check_eq("aw_timeout", 0, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            WVALID = 1'b1; WDATA = wd[b]; WSTRB = ws[b]; WLAST = wl[b];
            t = 0;
            do begin @(negedge ACLK); t++; end while (!WREADY && t < 200);
            if (!WREADY) check_eq("w_timeout", 0, 1);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    // Predict all beats from the model, then drive AR
    task automatic do_read(input logic [31:0] addr, input logic [7:0] id,
                           input logic [3:0] size, input logic [3:0] len);
        logic [31:0] a;
        rexp_t       e;
        int          t;
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            e.id   = id;
            e.last = (b == int'(len));
            if (mdl_err(a, size)) begin e.data = '0; e.resp = 2'b10; end
            else begin e.data = mdl[a[11:4]]; e.resp = 2'b00; end
            rq.push_back(e);
            a = a + (32'd1 << size);
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b1; ARADDR = addr; ARID = id; ARSIZE = size; ARLEN = len;
        t = 0;
        do begin @(negedge ACLK); t++; end while (!ARREADY && t < 200);
        if (!ARREADY) check_eq("ar_timeout", 0, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((rq.size() + bq.size()) != 0 && t < 2000) begin
            @(negedge ACLK);
            t++;
        end
        check_eq("drain", 160'(rq.size() + bq.size()), 0);
    endtask

    task automatic fill_beats(input int n, input logic [15:0] strb);
        for (int b = 0; b < 16; b++) begin
            wd[b] = {$urandom, $urandom, $urandom, $urandom};
            ws[b] = strb;
            wl[b] = (b == n - 1);
        end
    endtask

    // Ready generators
    initial begin
        forever begin
            @(posedge ACLK); #1;
            case (rmode)
                0:       RREADY = 1'b1;
                1:       RREADY = ~RREADY;
                default: RREADY = 1'($urandom_range(0, 1));
            endcase
            if (bhold > 0) begin
                BREADY = 1'b0;
                if (BVALID) bhold--;
            end else begin
                BREADY = 1'b1;
            end
        end
    end

    // Response monitors: scoreboard pops and hold-stability while stalled
    logic         r_stall = 1'b0;
    logic         b_stall = 1'b0;
    logic [159:0] r_saved;
    logic [159:0] b_saved;
    rexp_t        re;
    bexp_t        be;
    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                r_stall = 1'b0;
                b_stall = 1'b0;
            end else begin
                if (r_stall) check_eq("r_hold", {RVALID, RID, RRESP, RLAST, RDATA}, r_saved);
                if (b_stall) check_eq("b_hold", 160'({BVALID, BID, BRESP}), b_saved);
                r_stall = RVALID && !RREADY;
                r_saved = {RVALID, RID, RRESP, RLAST, RDATA};
                b_stall = BVALID && !BREADY;
                b_saved = 160'({BVALID, BID, BRESP});
                if (RVALID && RREADY) begin
                    if (rq.size() == 0) check_eq("r_unexpected", 1, 0);
                    else begin
                        re = rq.pop_front();
                        check_eq("rdata", RDATA, re.data);
                        check_eq("rresp", RRESP, re.resp);
                        check_eq("rlast", RLAST, re.last);
                        check_eq("rid", RID, re.id);
                    end
                end
                if (BVALID && BREADY) begin
                    if (bq.size() == 0) check_eq("b_unexpected", 1, 0);
                    else begin
                        be = bq.pop_front();
                        check_eq("bid", BID, be.id);
                        check_eq("bresp", BRESP, be.resp);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b0;
        AWADDR = '0; AWID = '0; AWSIZE = '0; AWLEN = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        ARADDR = '0; ARID = '0; ARSIZE = '0; ARLEN = '0; ARVALID = 1'b0;
        RREADY = 1'b1; BREADY = 1'b1;
        for (int i = 0; i < int'(MW); i++) mdl[i] = '0;

        repeat (3) @(negedge ACLK);
        check_eq("rst_outs", {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID,
                              RID, RRESP, RLAST, RDATA}, 0);
        ARESETn = 1'b1;
        #1 check_eq("ready_pre", 160'({AWREADY, ARREADY}), 0);
        @(negedge ACLK);
        check_eq("ready_post", 160'({AWREADY, ARREADY}), 160'(2'b11));

        // Fill the whole array so every later read is defined
        for (int w = 0; w < 16; w++) begin
            fill_beats(16, 16'hFFFF);
            do_write(32'(w * 256), 8'(w), 4'd4, 4'd15);
        end
        wait_idle();

        // Single beat write and read back
        fill_beats(1, 16'hFFFF);
        do_write(32'h10, 8'h5A, 4'd4, 4'd0);
        wait_idle();
        do_read(32'h10, 8'hA5, 4'd4, 4'd0);
        wait_idle();

        // Four beat burst with partial strobe on beat 2
        fill_beats(4, 16'hFFFF);
        ws[2] = 16'h00FF;
        do_write(32'h100, 8'h11, 4'd4, 4'd3);
        wait_idle();
        do_read(32'h100, 8'h12, 4'd4, 4'd3);
        wait_idle();

        // Eight beat read with RREADY toggling
        rmode = 1;
        do_read(32'h200, 8'h21, 4'd4, 4'd7);
        wait_idle();
        rmode = 0;

        // Burst running off the end of the array
        fill_beats(4, 16'hFFFF);
        do_write(32'((MW - 2) * 16), 8'h33, 4'd4, 4'd3);
        wait_idle();
        do_read(32'((MW - 2) * 16), 8'h34, 4'd4, 4'd3);
        wait_idle();

        // Narrow size, oversized size, and WLAST misplacement
        do_read(32'h300, 8'h41, 4'd3, 4'd3);
        wait_idle();
        fill_beats(1, 16'hFFFF);
        do_write(32'h400, 8'h42, 4'd5, 4'd0);
        wait_idle();
        do_read(32'h400, 8'h43, 4'd4, 4'd0);
        do_read(32'h400, 8'h44, 4'd5, 4'd1);
        wait_idle();
        fill_beats(3, 16'hF0F0);
        wl[2] = 1'b0;
        wl[1] = 1'b1;
        do_write(32'h500, 8'h45, 4'd4, 4'd2);
        wait_idle();
        do_read(32'h500, 8'h46, 4'd4, 4'd2);
        wait_idle();

        // Concurrent bursts with BREADY held off and random RREADY
        bhold = 5;
        rmode = 2;
        fill_beats(8, 16'hFFFF);
        fork
            do_write(32'h600, 8'h51, 4'd4, 4'd7);
            do_read(32'h800, 8'h52, 4'd4, 4'd7);
        join
        wait_idle();
        rmode = 0;

        // Reset during beat 2 of a 4 beat write
        fill_beats(4, 16'hFFFF);
        for (int b = 0; b < 2; b++) mdl[8'h70 + 8'(b)] = wd[b];
        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWADDR = 32'h700; AWID = 8'h61; AWSIZE = 4'd4; AWLEN = 4'd3;
        @(negedge ACLK);
        check_eq("rst_aw_rdy", 160'(AWREADY), 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int b = 0; b < 2; b++) begin
            WVALID = 1'b1; WDATA = wd[b]; WSTRB = ws[b]; WLAST = 1'b0;
            @(negedge ACLK);
            check_eq("rst_w_rdy", 160'(WREADY), 1);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b1; WDATA = wd[2]; WSTRB = ws[2];
        #2 ARESETn = 1'b0;
        #1 check_eq("rst_mid", 160'({AWREADY, WREADY, BVALID, ARREADY, RVALID}), 0);
        WVALID = 1'b0;
        @(posedge ACLK); #3;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check_eq("rst_aw_pre", 160'(AWREADY), 0);
        @(negedge ACLK);
        check_eq("rst_aw_post", 160'(AWREADY), 1);
        repeat (4) begin
            @(negedge ACLK);
            check_eq("rst_no_b", 160'(BVALID), 0);
        end
        do_read(32'h700, 8'h62, 4'd4, 4'd3);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
